// File: rtl/sha256_pkg.sv
// +--------------------------------------------------------------------------+
// | sha256_pkg                                                               |
// | SHA-256 constants, IV, bit functions and the core state encoding.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package sha256_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  localparam logic [31:0] c_k [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // H0 sits in the least significant word, matching the digest port layout.
  localparam logic [255:0] c_iv = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_round.sv
// +--------------------------------------------------------------------------+
// | sha256_round                                                             |
// | One combinational SHA-256 compression round; A is word 0, H is word 7.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] st_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] st_out
);

  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  assign w_a = st_in[31:0];
  assign w_b = st_in[63:32];
  assign w_c = st_in[95:64];
  assign w_d = st_in[127:96];
  assign w_e = st_in[159:128];
  assign w_f = st_in[191:160];
  assign w_g = st_in[223:192];
  assign w_h = st_in[255:224];

  assign w_t1 = w_h + bsig1(w_e) + ch(w_e, w_f, w_g) + k + w;
  assign w_t2 = bsig0(w_a) + maj(w_a, w_b, w_c);

  assign st_out = {w_g, w_f, w_e, w_d + w_t1, w_c, w_b, w_a, w_t1 + w_t2};

endmodule

`default_nettype wire

// File: rtl/sha256_chain_core.sv
// +--------------------------------------------------------------------------+
// | sha256_chain_core                                                        |
// | Multi-block SHA-256 compression core, UNROLL rounds per clock.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sha256_chain_core
  import sha256_pkg::*;
#(
  parameter int UNROLL  = 1,
  parameter int LAT_OUT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         out_last
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_chain_core: UNROLL must be 1, 2, 4 or 8");
  end
  if (LAT_OUT != 0 && LAT_OUT != 1) begin : g_bad_lat
    $error("sha256_chain_core: LAT_OUT must be 0 or 1");
  end

  localparam logic [1:0] c_st_idle  = S_IDLE;
  localparam logic [1:0] c_st_round = S_ROUND;
  localparam logic [1:0] c_st_final = S_FINAL;
  localparam logic [1:0] c_st_out   = S_OUT;
  localparam logic [5:0] c_step     = 6'(UNROLL);
  localparam logic [5:0] c_last_cnt = 6'(64 - UNROLL);

  logic [1:0]   r_state;
  logic [5:0]   r_cnt;
  logic         r_phase;
  logic         r_valid;
  logic         r_last;
  logic         r_out_last;
  logic [255:0] r_digest;
  logic [255:0] r_chain;
  logic [255:0] r_work;
  logic [255:0] r_h_init;
  logic [511:0] r_win;

  logic         w_accept;
  logic         w_emit;
  logic [255:0] w_start;
  logic [255:0] w_round_out;
  logic [255:0] w_sum;
  logic [255:0] w_emit_digest;
  logic [511:0] w_win_next;

  // Slides the 16-word window forward by UNROLL, generating the new words.
  function automatic logic [511:0] next_window(input logic [511:0] win);
    logic [31:0]  ext [0:23];
    logic [511:0] res;
    for (int i = 0; i < 16; i++) ext[i] = win[32*i +: 32];
    for (int j = 0; j < 8; j++)
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    for (int i = 0; i < 16; i++) res[32*i +: 32] = ext[i+UNROLL];
    return res;
  endfunction

  assign in_ready   = (r_state == c_st_idle) && reset_n;
  assign w_accept   = in_valid && in_ready && !abort;
  assign w_start    = in_first ? c_iv : r_chain;
  assign w_win_next = next_window(r_win);
  assign w_emit     = (r_state == c_st_final) && ((LAT_OUT == 0) || r_phase);

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    localparam logic [5:0] c_j = 6'(j);
    logic [255:0] w_st_in;
    logic [255:0] w_st_out;
    if (j == 0) begin : g_head
      assign w_st_in = r_work;
    end else begin : g_link
      assign w_st_in = g_round[j-1].w_st_out;
    end
    sha256_round u_round (
      .st_in  (w_st_in),
      .k      (c_k[r_cnt + c_j]),
      .w      (r_win[32*j +: 32]),
      .st_out (w_st_out)
    );
  end
  assign w_round_out = g_round[UNROLL-1].w_st_out;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++)
      w_sum[32*i +: 32] = r_h_init[32*i +: 32] + r_work[32*i +: 32];
  end

  // r_work is frozen throughout FINAL, so sampling the sum every cycle is safe.
  if (LAT_OUT == 1) begin : g_lat_reg
    logic [255:0] r_sum;
    always_ff @(posedge clk) r_sum <= w_sum;
    assign w_emit_digest = r_sum;
  end else begin : g_lat_comb
    assign w_emit_digest = w_sum;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_work   <= w_start;
      r_h_init <= w_start;
      r_win    <= in_block;
      r_last   <= in_last;
    end else if (r_state == c_st_round) begin
      r_work <= w_round_out;
      r_win  <= w_win_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= c_st_idle;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_valid    <= 1'b0;
      r_out_last <= 1'b0;
      r_digest   <= '0;
      r_chain    <= c_iv;
    end else if (abort) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_valid <= 1'b0;
      r_chain <= c_iv;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_state <= c_st_round;
            r_cnt   <= '0;
            r_phase <= 1'b0;
          end
        end
        c_st_round: begin
          r_cnt <= r_cnt + c_step;
          if (r_cnt == c_last_cnt) r_state <= c_st_final;
        end
        c_st_final: begin
          if (w_emit) begin
            r_digest   <= w_emit_digest;
            r_chain    <= w_emit_digest;
            r_valid    <= 1'b1;
            r_out_last <= r_last;
            r_phase    <= 1'b0;
            r_state    <= c_st_out;
          end else begin
            r_phase <= 1'b1;
          end
        end
        c_st_out: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign out_digest = r_digest;
  assign out_last   = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_sha256_chain_core.sv
// +--------------------------------------------------------------------------+
// | tb_sha256_chain_core                                                     |
// | Self-checking bench: known answers, reference-model chains, corner cases.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sha256_chain_core;

  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] TIV =
    256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
  localparam logic [255:0] ABC_DIG =
    256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
  localparam logic [255:0] TWO_DIG =
    256'h19db06c1_f6ecedd4_64ff2167_a33ce459_0c3e6039_e5c02693_d20638b8_248d6a61;

  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
    logic [255:0] exp_dig;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n, in_valid, in_first, in_last, abort, out_ready, aux_ready;
  logic [511:0] in_block;
  logic         in_ready, out_valid, out_last;
  logic [255:0] out_digest;
  logic         rdy2, vld2, last2, rdy4, vld4, last4, rdy8, vld8, last8, rdy0, vld0, last0;
  logic [255:0] dig2, dig4, dig8, dig0;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] chain;
  vec_t         tbl [6];

  always #5 clk = ~clk;

  sha256_chain_core #(.UNROLL(1), .LAT_OUT(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_first(in_first), .in_last(in_last), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest), .out_last(out_last));
  sha256_chain_core #(.UNROLL(2), .LAT_OUT(1)) u_u2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_block(in_block), .in_first(in_first), .in_last(in_last), .abort(abort),
    .out_valid(vld2), .out_ready(aux_ready), .out_digest(dig2), .out_last(last2));
  sha256_chain_core #(.UNROLL(4), .LAT_OUT(1)) u_u4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_block(in_block), .in_first(in_first), .in_last(in_last), .abort(abort),
    .out_valid(vld4), .out_ready(aux_ready), .out_digest(dig4), .out_last(last4));
  sha256_chain_core #(.UNROLL(8), .LAT_OUT(1)) u_u8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_block(in_block), .in_first(in_first), .in_last(in_last), .abort(abort),
    .out_valid(vld8), .out_ready(aux_ready), .out_digest(dig8), .out_last(last8));
  sha256_chain_core #(.UNROLL(1), .LAT_OUT(0)) u_l0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_block(in_block), .in_first(in_first), .in_last(in_last), .abort(abort),
    .out_valid(vld0), .out_ready(aux_ready), .out_digest(dig0), .out_last(last0));

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression over a full 64-word schedule.
  function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = h[32*i +: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[32*i +: 32] = h[32*i +: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Offers one block; returns the number of edges from acceptance to out_valid.
  task automatic send(input logic [511:0] blk, input logic first, input logic last,
                      output int lat);
    int g = 0;
    while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_wait in_ready=0 after %0d cycles, required 1", g);
    end
    in_valid = 1'b1; in_block = blk; in_first = first; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume(input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_valid_drop", {255'b0, out_valid}, 256'd0);
    check("hs_in_ready", {255'b0, in_ready}, 256'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hi;
    int lu1, lu2, lu4, lu8, ll0;
    logic [511:0] abc, b1, b2, blk;
    logic [31:0] msg [14];
    logic first, last;
    logic [255:0] exp;

    reset_n = 1'b0; in_valid = 1'b0; in_block = '0; in_first = 1'b0; in_last = 1'b0;
    abort = 1'b0; out_ready = 1'b0; aux_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {255'b0, in_ready}, 256'd0);
    check("rst_out_valid", {255'b0, out_valid}, 256'd0);
    check("rst_out_digest", out_digest, 256'd0);
    check("rst_out_last", {255'b0, out_last}, 256'd0);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", {255'b0, in_ready}, 256'd1);
    chain = TIV;

    abc = '0; abc[31:0] = 32'h61626380; abc[511:480] = 32'h00000018;
    msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
            32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
            32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
    b1 = '0;
    for (int i = 0; i < 14; i++) b1[32*i +: 32] = msg[i];
    b1[479:448] = 32'h80000000;
    b2 = '0; b2[511:480] = 32'h000001c0;

    tbl[0] = '{abc, 1'b1, 1'b1, ABC_DIG};
    tbl[1] = '{b1, 1'b1, 1'b0, ref_compress(TIV, b1)};
    tbl[2] = '{b2, 1'b0, 1'b1, TWO_DIG};
    tbl[3].blk = rand_blk(); tbl[3].first = 1'b0; tbl[3].last = 1'b0;
    tbl[3].exp_dig = ref_compress(TWO_DIG, tbl[3].blk);
    tbl[4].blk = rand_blk(); tbl[4].first = 1'b0; tbl[4].last = 1'b1;
    tbl[4].exp_dig = ref_compress(tbl[3].exp_dig, tbl[4].blk);
    tbl[5].blk = rand_blk(); tbl[5].first = 1'b1; tbl[5].last = 1'b1;
    tbl[5].exp_dig = ref_compress(TIV, tbl[5].blk);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].blk, tbl[i].first, tbl[i].last, lat);
      check($sformatf("tbl%0d_latency", i), 256'(lat), 256'd66);
      check($sformatf("tbl%0d_digest", i), out_digest, tbl[i].exp_dig);
      check($sformatf("tbl%0d_last", i), {255'b0, out_last}, {255'b0, tbl[i].last});
      consume(0);
      chain = tbl[i].exp_dig;
    end

    for (int i = 0; i < 8; i++) begin
      blk = rand_blk();
      first = ($urandom_range(0, 3) == 0);
      last = 1'($urandom_range(0, 1));
      exp = ref_compress(first ? TIV : chain, blk);
      send(blk, first, last, lat);
      check($sformatf("rnd%0d_latency", i), 256'(lat), 256'd66);
      check($sformatf("rnd%0d_digest", i), out_digest, exp);
      check($sformatf("rnd%0d_last", i), {255'b0, out_last}, {255'b0, last});
      consume($urandom_range(0, 3));
      check($sformatf("rnd%0d_digest_hold", i), out_digest, exp);
      chain = exp;
    end

    blk = rand_blk();
    exp = ref_compress(TIV, blk);
    send(blk, 1'b1, 1'b0, lat);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("stall_digest", out_digest, exp);
      check("stall_in_ready", {255'b0, in_ready}, 256'd0);
      check("stall_valid", {255'b0, out_valid}, 256'd1);
    end
    consume(0);
    check("stall_digest_after_hs", out_digest, exp);
    chain = exp;

    in_valid = 1'b1; in_block = rand_blk(); in_first = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chain = TIV;
    hi = 0;
    repeat (100) begin @(posedge clk); #1; if (out_valid) hi++; end
    check("abort_no_valid_cycles", 256'(hi), 256'd0);
    check("abort_in_ready", {255'b0, in_ready}, 256'd1);
    send(abc, 1'b0, 1'b1, lat);
    check("abort_then_abc_digest", out_digest, ABC_DIG);
    consume(0);
    chain = ABC_DIG;

    check("unroll_ready", {252'b0, rdy2, rdy4, rdy8, rdy0}, 256'hf);
    aux_ready = 1'b0;
    in_valid = 1'b1; in_block = abc; in_first = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lu1 = 0; lu2 = 0; lu4 = 0; lu8 = 0; ll0 = 0;
    for (int e = 1; e <= 100 && lu1 == 0; e++) begin
      @(posedge clk); #1;
      if (out_valid && lu1 == 0) lu1 = e;
      if (vld2 && lu2 == 0) lu2 = e;
      if (vld4 && lu4 == 0) lu4 = e;
      if (vld8 && lu8 == 0) lu8 = e;
      if (vld0 && ll0 == 0) ll0 = e;
    end
    check("u1_latency", 256'(lu1), 256'd66);
    check("u2_latency", 256'(lu2), 256'd34);
    check("u4_latency", 256'(lu4), 256'd18);
    check("u8_latency", 256'(lu8), 256'd10);
    check("lat0_latency", 256'(ll0), 256'd65);
    check("u1_digest", out_digest, ABC_DIG);
    check("u2_digest", dig2, ABC_DIG);
    check("u4_digest", dig4, ABC_DIG);
    check("u8_digest", dig8, ABC_DIG);
    check("lat0_digest", dig0, ABC_DIG);
    check("unroll_last", {252'b0, last2, last4, last8, last0}, 256'hf);
    aux_ready = 1'b1;
    consume(0);
    chain = ABC_DIG;

    blk = rand_blk();
    exp = ref_compress(chain, blk);
    send(blk, 1'b0, 1'b0, lat);
    check("preout_digest", out_digest, exp);
    reset_n = 1'b0;
    #1;
    check("rst_out_in_ready_low", {255'b0, in_ready}, 256'd0);
    @(posedge clk); #1;
    check("rst_out_valid", {255'b0, out_valid}, 256'd0);
    check("rst_out_digest_zero", out_digest, 256'd0);
    reset_n = 1'b1;
    #1;
    check("rst_out_in_ready_high", {255'b0, in_ready}, 256'd1);
    chain = TIV;
    send(abc, 1'b0, 1'b1, lat);
    check("rst_then_abc_latency", 256'(lat), 256'd66);
    check("rst_then_abc_digest", out_digest, ABC_DIG);
    consume(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
